instr_encoder: RTL and testbench

// - Inverse of the immediate/field decode path: packs RV32I fields (opcode, regs, funct, 32-bit imm)

---
 rtl/rv32_pkg.sv | 18 +
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_pack.sv | 47 ++++
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants and immediate range limits for the instruction encoder.
package rv32_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_R      = 7'b0110011;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   // Branch offsets are 13-bit signed and even.
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;

   typedef enum logic {StEmpty, StFull} enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus IMEM write port of the instruction encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [31:0]       imm;
   logic              imem_we;
   logic              imem_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: builds the instruction word and flags illegal bundles.
module instr_pack
   import rv32_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal,
   output logic        bad_range,
   output logic        bad_opcode
);
   logic signed [31:0] simm;

   assign simm  = $signed(imm);
   assign legal = ~bad_range & ~bad_opcode;

   always_comb begin
      word       = '0;
      bad_range  = 1'b0;
      bad_opcode = 1'b0;
      unique case (opcode)
         OP_IMM, OP_LOAD: begin
            word      = {imm[11:0], rs1, funct3, rd, opcode};
            bad_range = (simm < IMM12_MIN) || (simm > IMM12_MAX);
         end
         OP_STORE: begin
            word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            bad_range = (simm < IMM12_MIN) || (simm > IMM12_MAX);
         end
         OP_BRANCH: begin
            word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            bad_range = (simm < IMM13_MIN) || (simm > IMM13_MAX) || imm[0];
         end
         OP_R: begin
            word = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         default: begin
            bad_opcode = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV32I instructions into IMEM through a single-entry output register.
module instr_encoder
   import rv32_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   instr_encoder_if.slave        bus,
   output logic                  err_range,
   output logic                  err_opcode,
   output logic [15:0]           words_wr
);
   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

   enc_state_e        state_q, state_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_range_q, err_range_d;
   logic              err_opcode_q, err_opcode_d;
   logic [15:0]       words_q, words_d;

   logic [31:0] pack_word;
   logic        pack_legal, pack_bad_range, pack_bad_opcode;
   logic        accept, complete;

   instr_pack u_pack (
      .opcode     (bus.opcode),
      .rd         (bus.rd),
      .rs1        (bus.rs1),
      .rs2        (bus.rs2),
      .funct3     (bus.funct3),
      .funct7     (bus.funct7),
      .imm        (bus.imm),
      .word       (pack_word),
      .legal      (pack_legal),
      .bad_range  (pack_bad_range),
      .bad_opcode (pack_bad_opcode)
   );

   // Ready depends only on registered state and imem_ready, never on in_valid.
   assign bus.in_ready   = (state_q == StEmpty) | bus.imem_ready;
   assign bus.imem_we    = (state_q == StFull);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word_q;
   assign err_range      = err_range_q;
   assign err_opcode     = err_opcode_q;
   assign words_wr       = words_q;

   assign accept   = bus.in_valid & bus.in_ready;
   assign complete = (state_q == StFull) & bus.imem_ready;

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      addr_d       = addr_q;
      err_range_d  = err_range_q;
      err_opcode_d = err_opcode_q;
      words_d      = words_q;
      if (clear) begin
         state_d      = StEmpty;
         word_d       = '0;
         addr_d       = BaseAddr;
         err_range_d  = 1'b0;
         err_opcode_d = 1'b0;
      end else begin
         if (complete) begin
            addr_d  = addr_q + ADDR_W'(4);
            state_d = StEmpty;
            if (words_q != 16'hFFFF) begin
               words_d = words_q + 16'd1;
            end
         end
         // A new word loaded during completion keeps the register full without a bubble.
         if (accept && pack_legal) begin
            state_d = StFull;
            word_d  = pack_word;
         end
         if (accept && pack_bad_range) begin
            err_range_d = 1'b1;
         end
         if (accept && pack_bad_opcode) begin
            err_opcode_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StEmpty;
         word_q       <= '0;
         addr_q       <= BaseAddr;
         err_range_q  <= 1'b0;
         err_opcode_q <= 1'b0;
         words_q      <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         addr_q       <= addr_d;
         err_range_q  <= err_range_d;
         err_opcode_q <= err_opcode_d;
         words_q      <= words_d;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: queue-based write model plus hand-computed literal checks.
module tb_instr_encoder;
   import rv32_pkg::*;

   localparam int unsigned AW   = 4;
   localparam int unsigned BASE = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        err_range, err_opcode;
   logic [15:0] words_wr;

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .bus        (bus),
      .err_range  (err_range),
      .err_opcode (err_opcode),
      .words_wr   (words_wr)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int misses  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misses++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t           exp_q[$];
   logic [AW-1:0] m_ptr;
   bit            m_err_r, m_err_o;
   int            m_words;

   task automatic model_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm, output logic [31:0] w, output bit ok,
                            output bit badop);
      int si;
      si    = int'($signed(imm));
      w     = 32'h0;
      ok    = 1'b0;
      badop = 1'b0;
      if (op == OP_IMM || op == OP_LOAD) begin
         ok = si >= -2048 && si <= 2047;
         w  = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7)
              | 32'(op);
      end else if (op == OP_STORE) begin
         ok = si >= -2048 && si <= 2047;
         w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
              | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      end else if (op == OP_BRANCH) begin
         ok = si >= -4096 && si <= 4094 && (si & 1) == 0;
         w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
              | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      end else if (op == OP_R) begin
         ok = 1'b1;
         w  = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
              | (32'(rd) << 7) | 32'(op);
      end else begin
         badop = 1'b1;
      end
   endtask

   initial begin
      m_ptr   = AW'(BASE);
      m_err_r = 1'b0;
      m_err_o = 1'b0;
      m_words = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            m_ptr   = AW'(BASE);
            m_err_r = 1'b0;
            m_err_o = 1'b0;
            m_words = 0;
         end else if (clear) begin
            exp_q.delete();
            m_ptr   = AW'(BASE);
            m_err_r = 1'b0;
            m_err_o = 1'b0;
         end else begin
            bit          rdy, ok, badop;
            logic [31:0] w;
            wr_t         e;
            rdy = (exp_q.size() == 0) || bus.imem_ready;
            if (exp_q.size() != 0 && bus.imem_ready) begin
               void'(exp_q.pop_front());
               if (m_words < 65535) m_words++;
            end
            if (bus.in_valid && rdy) begin
               model_enc(bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm,
                         w, ok, badop);
               if (badop) m_err_o = 1'b1;
               else if (!ok) m_err_r = 1'b1;
               else begin
                  e.addr = m_ptr;
                  e.data = w;
                  exp_q.push_back(e);
                  m_ptr = m_ptr + AW'(4);
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("m_imem_we", 32'(bus.imem_we), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               check("m_imem_addr", 32'(bus.imem_addr), 32'(exp_q[0].addr));
               check("m_imem_wdata", bus.imem_wdata, exp_q[0].data);
            end
            check("m_in_ready", 32'(bus.in_ready), 32'((exp_q.size() == 0) || bus.imem_ready));
            check("m_err_range", 32'(err_range), 32'(m_err_r));
            check("m_err_opcode", 32'(err_opcode), 32'(m_err_o));
            check("m_words_wr", 32'(words_wr), 32'(m_words));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
      int n = 0;
      bit done = 1'b0;
      bus.opcode   = op;
      bus.rd       = rd;
      bus.rs1      = rs1;
      bus.rs2      = rs2;
      bus.funct3   = f3;
      bus.funct7   = f7;
      bus.imm      = imm;
      bus.in_valid = 1'b1;
      while (!done && n < 20) begin
         @(negedge clk);
         done = bus.in_ready;
         @(posedge clk);
         n++;
      end
      #1;
      bus.in_valid = 1'b0;
      if (!done) begin
         vectors++;
         misses++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, want 1", n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.opcode     = '0;
      bus.rd         = '0;
      bus.rs1        = '0;
      bus.rs2        = '0;
      bus.funct3     = '0;
      bus.funct7     = '0;
      bus.imm        = '0;
      bus.imem_ready = 1'b0;
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;

      check("rst_imem_we", 32'(bus.imem_we), 32'd0);
      check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
      check("rst_imem_wdata", bus.imem_wdata, 32'd0);
      check("rst_errs", 32'({err_range, err_opcode}), 32'd0);
      check("rst_words", 32'(words_wr), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // addi x1,x0,5
      send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      check("addi_wdata", bus.imem_wdata, 32'h0050_0093);
      check("addi_addr", 32'(bus.imem_addr), 32'h0);
      check("addi_we", 32'(bus.imem_we), 32'd1);
      check("addi_hold_ready", 32'(bus.in_ready), 32'd0);
      bus.imem_ready = 1'b1;
      idle(1);
      check("addi_words", 32'(words_wr), 32'd1);

      // sw x2,8(x1) then add x3,x1,x2 back-to-back
      pulse_clear();
      send(OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      check("sw_wdata", bus.imem_wdata, 32'h0020_A423);
      check("sw_addr", 32'(bus.imem_addr), 32'h0);
      send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      check("add_wdata", bus.imem_wdata, 32'h0020_81B3);
      check("add_addr", 32'(bus.imem_addr), 32'h4);
      idle(1);
      check("add_drained", 32'(bus.imem_we), 32'd0);
      check("add_words", 32'(words_wr), 32'd3);

      // beq x1,x2,-4 under back-pressure
      bus.imem_ready = 1'b0;
      send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) begin
         check("beq_wdata", bus.imem_wdata, 32'hFE20_8EE3);
         check("beq_in_ready", 32'(bus.in_ready), 32'd0);
         idle(1);
      end
      bus.imem_ready = 1'b1;
      idle(1);
      check("beq_words", 32'(words_wr), 32'd4);
      check("beq_ptr", 32'(bus.imem_addr), 32'hC);

      // Illegal bundles
      send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      check("rng_err", 32'(err_range), 32'd1);
      check("rng_no_we", 32'(bus.imem_we), 32'd0);
      check("rng_ptr", 32'(bus.imem_addr), 32'hC);
      pulse_clear();
      check("clr_errs", 32'({err_range, err_opcode}), 32'd0);
      send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
      check("b_odd_err", 32'({err_range, err_opcode}), 32'b10);
      send(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      check("op_err", 32'({err_range, err_opcode}), 32'b11);
      check("op_no_we", 32'(bus.imem_we), 32'd0);

      // Clear wins over a same-cycle accept
      clear = 1'b1;
      send(OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      clear = 1'b0;
      check("clr_drop_we", 32'(bus.imem_we), 32'd0);
      check("clr_drop_errs", 32'({err_range, err_opcode}), 32'd0);
      check("clr_ptr", 32'(bus.imem_addr), 32'h0);

      // Pointer wrap with ADDR_W=4
      for (int i = 0; i < 5; i++) begin
         send(OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'(i));
      end
      check("wrap_addr", 32'(bus.imem_addr), 32'h0);
      idle(1);
      check("wrap_words", 32'(words_wr), 32'd9);
      check("wrap_ptr", 32'(bus.imem_addr), 32'h4);

      // Asynchronous reset while a word is held
      bus.imem_ready = 1'b0;
      send(OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      check("arst_we", 32'(bus.imem_we), 32'd0);
      check("arst_words", 32'(words_wr), 32'd0);
      check("arst_addr", 32'(bus.imem_addr), 32'h0);
      check("arst_wdata", bus.imem_wdata, 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      bus.imem_ready = 1'b1;
      idle(3);
      check("arst_no_write", 32'(bus.imem_we), 32'd0);
      check("arst_words_after", 32'(words_wr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule
